// File: rtl/turn_scheduler.sv
// Turn/round controller for the two-player artillery game: keyboard grant, fire, shell flight, hits, game over.
// Optional macro TURN_TIMEOUT_EN builds the per-turn tick timer and forced turn switch.
module turn_scheduler #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned TURN_TICKS  = 30,
    parameter int unsigned HIT_STRETCH = 8,
    parameter int unsigned FLIGHT_MAX  = 16'hFFFF
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [6:0] key_in,
    input  logic [7:0] p1_health,
    input  logic [7:0] p2_health,
    input  logic       shell_done,
    input  logic       shell_hit_p1,
    input  logic       shell_hit_p2,
    output logic [6:0] p1_key,
    output logic [6:0] p2_key,
    output logic       fire,
    output logic       active_player,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic [7:0] turn_timer,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int unsigned WD_W   = $clog2(FLIGHT_MAX + 1);
    localparam int unsigned STR_W  = (HIT_STRETCH > 1) ? $clog2(HIT_STRETCH) : 1;
    localparam logic [7:0]  TICKS_INIT = 8'(TURN_TICKS);
    localparam logic [6:0]  FIRE_KEY   = 7'b10_00001;

    typedef enum logic [2:0] {
        ST_TURN,
        ST_FLIGHT,
        ST_RESOLVE,
        ST_SWITCH,
        ST_OVER
    } state_t;

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic             fire_q, fire_d;
    logic             hit1_q, hit1_d;
    logic             hit2_q, hit2_d;
    logic [STR_W-1:0] cnt1_q, cnt1_d;
    logic [STR_W-1:0] cnt2_q, cnt2_d;
    logic [7:0]       snap1_q, snap1_d;
    logic [7:0]       snap2_q, snap2_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             over_q, over_d;
    logic [1:0]       winner_q, winner_d;
    logic             p1_dead, p2_dead;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [7:0]         timer_q, timer_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    assign turn_timer = timer_q;
`else
    // Without the timer the tick divider has no function; a turn ends only by firing.
    if (TICK_DIV == 0) begin : g_tick_div_unused
    end
    assign turn_timer = TICKS_INIT;
`endif

    assign p1_dead = (p1_health == 8'd0);
    assign p2_dead = (p2_health == 8'd0);

    // Keyboard grant: only the active player sees the stream, and only during its turn.
    always_comb begin
        p1_key = 7'd0;
        p2_key = 7'd0;
        if (rst_n && state_q == ST_TURN) begin
            if (active_q) p2_key = key_in;
            else          p1_key = key_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        fire_d   = 1'b0;
        hit1_d   = hit1_q;
        hit2_d   = hit2_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        snap1_d  = snap1_q;
        snap2_d  = snap2_q;
        wd_d     = wd_q;
        over_d   = over_q;
        winner_d = winner_q;
`ifdef TURN_TIMEOUT_EN
        timer_d  = timer_q;
        presc_d  = presc_q;
`endif
        unique case (state_q)
            ST_TURN: begin
                if (key_in == FIRE_KEY) begin
                    fire_d  = 1'b1;
                    wd_d    = '0;
                    state_d = ST_FLIGHT;
                end
`ifdef TURN_TIMEOUT_EN
                else if (timer_q == 8'd0) begin
                    state_d = ST_SWITCH;
                end else if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    timer_d = timer_q - 8'd1;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
`endif
            end
            ST_FLIGHT: begin
                if (shell_done) begin
                    hit1_d  = shell_hit_p1;
                    hit2_d  = shell_hit_p2;
                    snap1_d = p1_health;
                    snap2_d = p2_health;
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    state_d = ST_RESOLVE;
                end else if (wd_q == WD_W'(FLIGHT_MAX - 1)) begin
                    state_d = ST_SWITCH;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESOLVE: begin
                // Each strobe ends on a health change or stretch expiry, independently.
                if (hit1_q) begin
                    if (p1_health != snap1_q || cnt1_q == STR_W'(HIT_STRETCH - 1)) hit1_d = 1'b0;
                    else cnt1_d = cnt1_q + STR_W'(1);
                end
                if (hit2_q) begin
                    if (p2_health != snap2_q || cnt2_q == STR_W'(HIT_STRETCH - 1)) hit2_d = 1'b0;
                    else cnt2_d = cnt2_q + STR_W'(1);
                end
                if (!hit1_d && !hit2_d) state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
                active_d = ~active_q;
`ifdef TURN_TIMEOUT_EN
                timer_d  = TICKS_INIT;
                presc_d  = '0;
`endif
                state_d  = ST_TURN;
            end
            ST_OVER: begin
            end
            default: state_d = ST_TURN;
        endcase

        // A dead player ends the game ahead of any other transition.
        if (state_q != ST_OVER && (p1_dead || p2_dead)) begin
            state_d  = ST_OVER;
            over_d   = 1'b1;
            winner_d = {p1_dead, p2_dead};
            fire_d   = 1'b0;
            hit1_d   = 1'b0;
            hit2_d   = 1'b0;
            active_d = active_q;
`ifdef TURN_TIMEOUT_EN
            timer_d  = timer_q;
            presc_d  = presc_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_TURN;
            active_q <= 1'b0;
            fire_q   <= 1'b0;
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            snap1_q  <= 8'd0;
            snap2_q  <= 8'd0;
            wd_q     <= '0;
            over_q   <= 1'b0;
            winner_q <= 2'b00;
`ifdef TURN_TIMEOUT_EN
            timer_q  <= TICKS_INIT;
            presc_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            fire_q   <= fire_d;
            hit1_q   <= hit1_d;
            hit2_q   <= hit2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            snap1_q  <= snap1_d;
            snap2_q  <= snap2_d;
            wd_q     <= wd_d;
            over_q   <= over_d;
            winner_q <= winner_d;
`ifdef TURN_TIMEOUT_EN
            timer_q  <= timer_d;
            presc_q  <= presc_d;
`endif
        end
    end

    assign fire          = fire_q;
    assign active_player = active_q;
    assign hit_p1        = hit1_q;
    assign hit_p2        = hit2_q;
    assign game_over     = over_q;
    assign winner        = winner_q;

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Round/turn controller for the two-player artillery game; sits between the keyboard decoder, both player instances and the shell (projectile) engine.
- Grants the shared keyboard stream to exactly one player at a time, detects the fire command, sequences shell flight and hit delivery, and declares game over and the winner.
- All state runs on the fast system clock.

Parameters:
- TICK_DIV, 50000000: clock cycles per turn-timer tick (1 s at 50 MHz).
- TURN_TICKS, 30: ticks allowed per turn before forced switch.
- HIT_STRETCH, 8: maximum cycles a hit output is held high.
- FLIGHT_MAX, 16'hFFFF: watchdog cycles in FLIGHT before the shot is treated as a miss.

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  7  keyboard stream; [6:5] edge code (01 posedge, 11 hold, 10 negedge, 00 none), [4:0] one-hot command (00001 = hold_cannon)
- p1_health  in  8  player 1 health
- p2_health  in  8  player 2 health
- shell_done  in  1  1-cycle pulse: shell landed
- shell_hit_p1  in  1  valid with shell_done: player 1 struck
- shell_hit_p2  in  1  valid with shell_done: player 2 struck
- p1_key  out  7  keyboard stream routed to player 1
- p2_key  out  7  keyboard stream routed to player 2
- fire  out  1  1-cycle launch pulse to the shell engine
- active_player  out  1  0 = player 1, 1 = player 2
- hit_p1  out  1  hit strobe to player 1
- hit_p2  out  1  hit strobe to player 2
- turn_timer  out  8  ticks remaining in current turn
- game_over  out  1  sticky end-of-game flag
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw

Behaviour:
- Clock is `clock`; reset is `rst_n`, asynchronous and active-low.
- Reset values:
  - state = TURN, active_player = 0.
  - turn_timer = TURN_TICKS, prescaler = 0.
  - fire, hit_p1, hit_p2, game_over = 0; winner = 00.
  - p1_key, p2_key = 0.
- Reset mid-operation aborts any flight or hit strobe immediately.
- Key routing (combinational):
  - In TURN, the active player's key output = key_in; the other = 7'b0.
  - In all other states, both key outputs = 0.
- States:
  - TURN:
    - Prescaler counts 0..TICK_DIV-1; at wrap, turn_timer decrements.
    - key_in == {10, 00001} (hold_cannon released): fire = 1 for one cycle, go to FLIGHT.
    - turn_timer == 0 without a fire: go to SWITCH.
    - Fire and timeout in the same cycle: fire wins.
  - FLIGHT:
    - Watchdog counts cycles.
    - On shell_done, latch the hit flags and go to RESOLVE.
    - Watchdog reaching FLIGHT_MAX: treat as a miss, go to SWITCH.
  - RESOLVE:
    - Drive hit_pX high for each latched flag.
    - A strobe drops when that player's health input changes from its value at RESOLVE entry, or after HIT_STRETCH cycles, whichever is first.
    - Leave for SWITCH when all strobes have dropped.
    - Both players hit: both strobes run independently.
  - SWITCH (1 cycle):
    - Toggle active_player.
    - turn_timer = TURN_TICKS, prescaler = 0.
    - Go to TURN.
  - OVER:
    - Absorbing; outputs frozen except the key outputs, which are 0.
    - Only reset exits.
- Game-over check, every cycle in every state except OVER, with priority over all transitions:
  - If p1_health == 0 or p2_health == 0, enter OVER next cycle and set game_over = 1.
  - winner = 10 if only p1 is zero, 01 if only p2 is zero, 11 if both are zero.
  - Any active hit strobe is cleared on entry to OVER.
- Width rules:
  - turn_timer saturates at 0.
  - TURN_TICKS is truncated to 8 bits.
  - The prescaler is sized with $clog2(TICK_DIV).

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined: turn timer and prescaler are active as described.
- Undefined:
  - The timer logic is removed; turn_timer is tied to TURN_TICKS.
  - A turn ends only by firing.
  - The FLIGHT watchdog is still present.

Test Plan:
- Reset, then key_in = {01,00001}, {11,00001}, {10,00001} -> p1_key mirrors the stream, p2_key = 0, fire pulses exactly 1 cycle on the negedge code, state FLIGHT.
- In FLIGHT, shell_done with shell_hit_p2 = 1; p2_health 8'h80 -> 8'h60 after 3 cycles -> hit_p2 high for exactly 3 cycles, then active_player = 1, turn_timer = TURN_TICKS.
- TICK_DIV = 4, TURN_TICKS = 3, no input -> turn_timer 3,2,1,0 every 4 cycles, then active_player toggles, no fire.
- Hit with health never changing, HIT_STRETCH = 8 -> hit_p1 high exactly 8 cycles, then SWITCH.
- Both healths driven to 0 in the same cycle during TURN -> game_over = 1 next cycle, winner = 11; further key_in is not routed and there is no fire.
- Fire negedge and timer expiry in the same cycle -> fire pulses, no switch; also assert rst_n low during RESOLVE -> all outputs return to reset values asynchronously.
